// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its users (decode, writeback).
package regfile_pkg;

   // Index of the register that reads as zero when the hardwired-zero option is on
   localparam int ZERO_REG_IDX = 0;

   // Default geometry shared with decode and writeback
   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;
   localparam int DEF_NREAD = 2;

   // Address width needed to index DEPTH registers (at least one bit)
   function automatic int calc_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_mp_mux_n.sv
// N:1 word selector; a select value at or beyond N returns all zeros.
module mux_n #(
   parameter int WIDTH = 32,
   parameter int N     = 32,
   parameter int SW    = (N < 2) ? 1 : $clog2(N)
) (
   input  logic [N*WIDTH-1:0] din,
   input  logic [SW-1:0]      sel,
   output logic [WIDTH-1:0]   dout
);

   // Scan every word so that an out-of-range select simply matches nothing
   always_comb begin
      dout = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(sel) == i) begin
            dout = din[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional zero register,
// write-to-read bypass and registered read data.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NREAD    = DEF_NREAD,
   parameter int AW       = calc_aw(DEPTH),
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   parameter int READ_LAT = 0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [WIDTH-1:0]       wdata,
   input  logic [NREAD*AW-1:0]    raddr,
   output logic [NREAD*WIDTH-1:0] rdata,
   output logic                   wr_err
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG_IDX);
   localparam logic [AW:0]   DEPTH_X   = DEPTH[AW:0];

   logic [WIDTH-1:0]       regs_q [DEPTH];
   logic [WIDTH-1:0]       regs_d [DEPTH];
   logic [DEPTH*WIDTH-1:0] regs_flat;
   logic                   wr_err_q;
   logic                   wr_err_d;
   logic                   wr_in_range;
   logic                   wr_to_zero;
   logic                   wr_legal;
   logic [NREAD*WIDTH-1:0] rdata_d;

   // Classify the write: legal writes update a register, out-of-range ones raise wr_err
   always_comb begin
      wr_in_range = ({1'b0, waddr} < DEPTH_X);
      wr_to_zero  = ZERO_REG && (waddr == ZERO_ADDR);
      wr_legal    = we && wr_in_range && !wr_to_zero;
      wr_err_d    = we && !wr_in_range;
   end

   // Next register array contents: only the addressed entry changes on a legal write
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_legal && (waddr == AW'(i))) begin
            regs_d[i] = wdata;
         end
      end
   end

   // Flatten the array so each read port can select from it
   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
      end
   end

   // Register array and error pulse; reset wins over a same-edge write
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         wr_err_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         wr_err_q <= wr_err_d;
      end
   end

   assign wr_err = wr_err_q;

   for (genvar k = 0; k < NREAD; k++) begin : g_port
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] mux_out;
      logic [WIDTH-1:0] rd_val;

      assign ra = raddr[k*AW +: AW];

      mux_n #(
         .WIDTH (WIDTH),
         .N     (DEPTH),
         .SW    (AW)
      ) u_mux (
         .din  (regs_flat),
         .sel  (ra),
         .dout (mux_out)
      );

      // Read value priority: out of range, zero register, bypass, then stored data
      always_comb begin
         rd_val = mux_out;
         if ({1'b0, ra} >= DEPTH_X) begin
            rd_val = '0;
         end else if (ZERO_REG && (ra == ZERO_ADDR)) begin
            rd_val = '0;
         end else if (BYPASS && wr_legal && (waddr == ra)) begin
            rd_val = wdata;
         end
      end

      assign rdata_d[k*WIDTH +: WIDTH] = rd_val;
   end

   if (READ_LAT == 1) begin : g_reg_read
      logic [NREAD*WIDTH-1:0] rdata_q;

      // Registered read data: one cycle from address to data
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            rdata_q <= '0;
         end else begin
            rdata_q <= rdata_d;
         end
      end

      assign rdata = rdata_q;
   end else begin : g_comb_read
      assign rdata = rdata_d;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the processor datapath.
- Generalises the fixed 32-entry/32-bit word selector: depth, width and read-port count are parameters.
- Adds an optional hardwired-zero register, write-to-read bypass and a registered-read mode.
- Sits between decode (read addresses) and execute (operands); writeback drives the write port.

Parameters:
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 32, number of registers (>=2, need not be a power of two)
- NREAD, 2, number of independent read ports (1..4)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to rdata
- READ_LAT, 0, 0 = combinational read; 1 = read data registered (one-cycle latency)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- we  in  1  write enable, sampled on rising clock
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr  in  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW]
- rdata  out  NREAD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH]
- wr_err  out  1  registered pulse: the previous cycle had a write with waddr >= DEPTH

Behaviour:
- Reset: clock and reset_n are the only timing inputs. reset_n low asynchronously clears all DEPTH registers, the READ_LAT=1 output registers and wr_err to 0.
- Reset mid-operation: an asserted reset_n overrides any same-edge write. Release is synchronous to the next rising edge; the first write is accepted on the first edge with reset_n high.
- Write: on rising clock with we=1 and waddr < DEPTH, regs[waddr] <= wdata.
  - ZERO_REG=1 and waddr=0: write dropped silently; wr_err not set.
  - waddr >= DEPTH: write dropped and wr_err=1 for exactly the following cycle. Otherwise wr_err=0.
- Read value per port k, computed combinationally:
  - raddr_k >= DEPTH -> 0.
  - Else ZERO_REG=1 and raddr_k=0 -> 0.
  - Else BYPASS=1 and we=1 and waddr=raddr_k and the write is legal (not dropped) -> wdata.
  - Else regs[raddr_k].
- READ_LAT=0: rdata_k equals the read value in the same cycle.
  - BYPASS=0 returns the old contents during a same-cycle write.
  - The new value appears the cycle after the edge.
- READ_LAT=1: rdata_k <= read value at each rising clock.
  - Latency is exactly 1 cycle from raddr to rdata.
  - With BYPASS=1, a write at edge N to the address presented before edge N is returned at edge N.
- Multiple read ports may present the same address; each gets an identical value. No arbitration and no stalls.
- Width rules:
  - All comparisons are unsigned on AW bits.
  - rdata is never X after reset: unused or invalid addresses return 0.
- No internal state other than the register array, the optional output registers and wr_err.

Decomposition:
- Shared package regfile_pkg holds:
  - the constant for the hardwired-zero register index;
  - a localparam function for the AW derivation;
  - the default WIDTH/DEPTH/NREAD values, reused by decode and writeback.
- Natural sub-module: mux_n.
  - Parametrised DEPTH:1 word selector (WIDTH, N), out-of-range select -> 0.
  - Instantiated once per read port inside a generate loop.
  - Bypass and zero logic live in regfile_mp, not in mux_n.

Test Plan:
1. Reset and zero register: assert reset_n=0 mid-stream, then release. All rdata=0. Write we=1, waddr=0, wdata=32'hDEADBEEF, then read raddr=0 -> 0, wr_err=0.
2. Basic write/read: write reg 5 = 32'h12345678 and reg 23 = 32'hCAFEF00D. Next cycle raddr={23,5} -> port0=32'h12345678, port1=32'hCAFEF00D. Distinct upper-half addresses 16..23 all return their own data.
3. Bypass, READ_LAT=0: reg 7 holds 32'h1. Same cycle, we=1, waddr=7, wdata=32'h2, raddr0=7.
   - BYPASS=1 -> rdata0=32'h2 that cycle.
   - BYPASS=0 -> 32'h1 that cycle, then 32'h2 after the edge.
4. Registered read, READ_LAT=1: change raddr0 3->9 at cycle N (reg 3 = 32'hA, reg 9 = 32'hB). rdata0 = 32'hA through cycle N and 32'hB from edge N+1. A write to 9 with bypass at edge N+1 shows the new data at N+1.
5. Out-of-range with DEPTH=24: write waddr=30 -> no register changes and wr_err=1 for one cycle. raddr=28 -> rdata=0.
6. Reset during write: reset_n low at the same time as a write edge to reg 4 = 32'hFF. Reg 4 reads 0 after release, and the first post-release write succeeds.
